// File: rtl/glitch_seq_pkg.sv
// glitch_seq_pkg: shared FSM states and datapath vector bit positions for the glitch test sequencer
package glitch_seq_pkg;
  typedef enum logic [2:0] {IDLE, APPLY_INIT, SETTLE, APPLY_FINAL, WATCH, REPORT} state_t;
  localparam int IDX_A = 3;
  localparam int IDX_B = 2;
  localparam int IDX_C = 1;
  localparam int IDX_D = 0;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/glitch_test_sequencer.sv
// glitch_test_sequencer: drives init/final vectors into the glitch detector and reports F edges and a hazard verdict
// Optional run statistics (run_cnt, glitch_total) are enabled by defining GLITCH_SEQ_STATS_EN.
module glitch_test_sequencer
  import glitch_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int WIN_CYC    = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       case_init,
  input  logic [3:0]       case_final,
  output logic [3:0]       abcd,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             f_init,
  output logic             f_final,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             glitch
`ifdef GLITCH_SEQ_STATS_EN
  ,
  output logic [7:0]       run_cnt,
  output logic [7:0]       glitch_total
`endif
);
  localparam int CMAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int CW = $clog2(CMAX + 1);
  state_t state, nxt;
  logic [3:0] init_q, final_q;
  logic [CW-1:0] cnt;
  logic [CNT_W-1:0] ecnt, ecnt_nx;
  logic f_s, prev, init_s, settle_end, watch_end, glitch_nx;
  sync2 u_sync (
    .clk(clk),
    .rst(rst),
    .d  (f_in),
    .q  (f_s)
  );
  assign settle_end = (state == SETTLE) && (cnt == CW'(SETTLE_CYC - 1));
  assign watch_end  = (state == WATCH) && (cnt == CW'(WIN_CYC - 1));
  assign ecnt_nx    = ((f_s != prev) && (ecnt != '1)) ? ecnt + 1'b1 : ecnt;
  // a saturated counter is treated as more than one edge
  assign glitch_nx  = (init_s == f_s) ? (ecnt_nx != '0) : ((ecnt_nx > CNT_W'(1)) || (&ecnt_nx));
  always_comb begin
    nxt  = state;
    busy = state != IDLE;
    done = state == REPORT;
    case (state)
      IDLE:        nxt = start ? APPLY_INIT : IDLE;
      APPLY_INIT:  nxt = SETTLE;
      SETTLE:      nxt = settle_end ? APPLY_FINAL : SETTLE;
      APPLY_FINAL: nxt = WATCH;
      WATCH:       nxt = watch_end ? REPORT : WATCH;
      default:     nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      abcd     <= '0;
      init_q   <= '0;
      final_q  <= '0;
      cnt      <= '0;
      ecnt     <= '0;
      prev     <= 1'b0;
      init_s   <= 1'b0;
      f_init   <= 1'b0;
      f_final  <= 1'b0;
      edge_cnt <= '0;
      glitch   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        init_q  <= case_init;
        final_q <= case_final;
      end
      abcd <= (state == APPLY_INIT) ? init_q : (state == APPLY_FINAL) ? final_q : abcd;
      cnt  <= (state == SETTLE || state == WATCH) ? cnt + 1'b1 : '0;
      if (settle_end) begin
        init_s <= f_s;
        prev   <= f_s;
      end
      if (state == APPLY_FINAL) ecnt <= '0;
      if (state == WATCH) begin
        ecnt <= ecnt_nx;
        prev <= f_s;
      end
      // results land on the REPORT entry edge so they are valid alongside done
      if (watch_end) begin
        f_init   <= init_s;
        f_final  <= f_s;
        edge_cnt <= ecnt_nx;
        glitch   <= glitch_nx;
      end
    end
`ifdef GLITCH_SEQ_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      run_cnt      <= '0;
      glitch_total <= '0;
    end else if (done) begin
      run_cnt      <= run_cnt + {7'd0, ~&run_cnt};
      glitch_total <= glitch_total + {7'd0, glitch & ~&glitch_total};
    end
`endif
endmodule

// File: tb/tb_glitch_test_sequencer.sv
// tb_glitch_test_sequencer: table-driven runs with hand-computed results plus reset, abort and saturation sequences
module tb_glitch_test_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, f_in = 1'b0;
  logic [3:0] case_init = '0, case_final = '0;
  logic [3:0] abcd, abcd2, edge_cnt, edge_cnt2;
  logic busy, done, f_init, f_final, glitch;
  logic busy2, done2, f_init2, f_final2, glitch2;
`ifdef GLITCH_SEQ_STATS_EN
  logic [7:0] run_cnt, glitch_total, run_cnt2, glitch_total2;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  glitch_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .case_init(case_init), .case_final(case_final),
    .abcd(abcd), .f_in(f_in), .busy(busy), .done(done), .f_init(f_init), .f_final(f_final),
    .edge_cnt(edge_cnt), .glitch(glitch)
`ifdef GLITCH_SEQ_STATS_EN
    , .run_cnt(run_cnt), .glitch_total(glitch_total)
`endif
  );
  glitch_test_sequencer #(.WIN_CYC(20)) dut_long (
    .clk(clk), .rst(rst), .start(start), .case_init(case_init), .case_final(case_final),
    .abcd(abcd2), .f_in(f_in), .busy(busy2), .done(done2), .f_init(f_init2), .f_final(f_final2),
    .edge_cnt(edge_cnt2), .glitch(glitch2)
`ifdef GLITCH_SEQ_STATS_EN
    , .run_cnt(run_cnt2), .glitch_total(glitch_total2)
`endif
  );
  typedef struct {
    logic [3:0]  ini, fin;
    logic [31:0] fpat, spat;
    logic        ef_init, ef_final;
    logic [3:0]  edges;
    logic        eg;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // fpat[k] is f_in during cycle k after the start cycle; f_s lags it by two cycles
  task automatic run(input vec_t v);
    int dcyc = 0;
    case_init  = v.ini;
    case_final = v.fin;
    for (int k = 0; k < 20; k++) begin
      f_in  = v.fpat[k];
      start = (k == 0) || v.spat[k];
      @(posedge clk);
      #1;
      if (k + 1 == 4) begin
        chk("abcd_init", abcd, v.ini);
        chk("busy_run", busy, 1);
      end
      if (done && dcyc == 0) begin
        dcyc = k + 1;
        chk("done_latency", dcyc, 15);
        chk("abcd_final", abcd, v.fin);
        chk("busy_report", busy, 1);
        chk("f_init", f_init, v.ef_init);
        chk("f_final", f_final, v.ef_final);
        chk("edge_cnt", edge_cnt, v.edges);
        chk("glitch", glitch, v.eg);
      end
      if (k + 1 == 17) chk("idle_after", {busy, done}, 0);
    end
    start = 1'b0;
    if (dcyc == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within 20 cycles");
    end
  endtask
  initial begin
    int seen, d2, er, eg;
    vt[0] = '{4'b1000, 4'b0000, 32'hFFFF_FFFF, 32'h0,   1'b1, 1'b1, 4'd0, 1'b0};
    vt[1] = '{4'b1000, 4'b0000, 32'hFFFF_FE7F, 32'h0,   1'b1, 1'b1, 4'd2, 1'b1};
    vt[2] = '{4'b1010, 4'b0010, 32'h0000_00BF, 32'h0,   1'b1, 1'b0, 4'd3, 1'b1};
    vt[3] = '{4'b1010, 4'b0010, 32'h0000_00FF, 32'h0,   1'b1, 1'b0, 4'd1, 1'b0};
    vt[4] = '{4'b0001, 4'b0101, 32'hFFFF_FF00, 32'h0,   1'b0, 1'b1, 4'd1, 1'b0};
    vt[5] = '{4'b1100, 4'b0100, 32'hFFFF_FFFF, 32'h200, 1'b1, 1'b1, 4'd0, 1'b0};
    vt[6] = '{4'b0110, 4'b0110, 32'h0000_0400, 32'h0,   1'b0, 1'b0, 4'd2, 1'b1};
    start = 1'b1;
    case_init = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_abcd", abcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_glitch", glitch, 0);
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_f_init", f_init, 0);
    chk("rst_f_final", f_final, 0);
    foreach (vt[i]) run(vt[i]);
    // abort a run in SETTLE and confirm it never reports
    case_init  = 4'b1111;
    case_final = 4'b0000;
    f_in  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_abcd_pre", abcd, 4'b1111);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_abcd", abcd, 0);
    chk("abort_glitch", glitch, 0);
    chk("abort_edge_cnt", edge_cnt, 0);
    chk("abort_f_init", f_init, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    er = 0;
    eg = 0;
    for (int i = 0; i < 3; i++) begin
      run(vt[i]);
      er++;
      eg += int'(vt[i].eg);
    end
`ifdef GLITCH_SEQ_STATS_EN
    chk("run_cnt", run_cnt, er);
    chk("glitch_total", glitch_total, eg);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d2 = 0;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      f_in = k[0];
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done2 && d2 == 0) begin
        d2 = k + 1;
        chk("sat_latency", d2, 27);
        chk("sat_edge_cnt", edge_cnt2, 15);
        chk("sat_glitch", glitch2, 1);
      end
    end
    if (d2 == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sat_timeout: no done within 40 cycles");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
